// File: rtl/change_dispense_sequencer.sv
// change_dispense_sequencer
// Pays out change after a vend by firing coin hoppers greedily (5, 2, then 1),
// skipping empty hoppers. Each coin is confirmed on its sense line before the
// next selection. The block reports completion, or a fault with the unpaid residue.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid_i      change request present
//   req_amount_i     change to pay, in unit coins
//   req_ready_o      high only in IDLE
//   hopper_empty_i   {5-unit, 2-unit, 1-unit} empty flags, sampled in SELECT
//   coin_sense_i     one-cycle pulse per ejected coin, same bit mapping
//   coin_fire_o      one-hot hopper fire pulse
//   busy_o           high in every state except IDLE
//   done_o           one-cycle end-of-transaction pulse
//   fault_o          transaction ended with unpaid residue; held until next accept
//   remaining_o      unpaid amount
//   coin_count_o     coins ejected in current/last transaction, saturating
module change_dispense_sequencer #(
  parameter int unsigned AMT_W        = 8,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT  = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  input  logic [AMT_W-1:0] req_amount_i,
  output logic             req_ready_o,
  input  logic [2:0]       hopper_empty_i,
  input  logic [2:0]       coin_sense_i,
  output logic [2:0]       coin_fire_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fault_o,
  output logic [AMT_W-1:0] remaining_o,
  output logic [AMT_W-1:0] coin_count_o
);

  localparam int unsigned PCNT_W = 8;
  localparam int unsigned TMR_W  = 16;

  localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMO_LAST   = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [AMT_W-1:0]  VAL5       = AMT_W'(5);
  localparam logic [AMT_W-1:0]  VAL2       = AMT_W'(2);
  localparam logic [AMT_W-1:0]  VAL1       = AMT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_FIRE,
    ST_WAIT_ACK,
    ST_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [AMT_W-1:0]    remaining_q, remaining_d;
  logic [AMT_W-1:0]    coin_count_q, coin_count_d;
  logic                fault_q, fault_d;
  logic [2:0]          sel_q, sel_d;
  logic [PCNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [TMR_W-1:0]    timer_q, timer_d;

  logic                can5_c, can2_c, can1_c;
  logic                sense_hit_c;
  logic [AMT_W-1:0]    sel_val_c;

  // Hopper eligibility: denomination fits the residue and hopper is not empty
  assign can5_c = (remaining_q >= VAL5) && !hopper_empty_i[2];
  assign can2_c = (remaining_q >= VAL2) && !hopper_empty_i[1];
  assign can1_c = (remaining_q >= VAL1) && !hopper_empty_i[0];

  // Only the sense bit of the hopper just fired counts as confirmation
  assign sense_hit_c = |(coin_sense_i & sel_q);
  assign sel_val_c   = sel_q[2] ? VAL5 : (sel_q[1] ? VAL2 : VAL1);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      coin_count_q <= '0;
      fault_q      <= 1'b0;
      sel_q        <= 3'b000;
      pulse_cnt_q  <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      coin_count_q <= coin_count_d;
      fault_q      <= fault_d;
      sel_q        <= sel_d;
      pulse_cnt_q  <= pulse_cnt_d;
      timer_q      <= timer_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    coin_count_d = coin_count_q;
    fault_d      = fault_q;
    sel_d        = sel_q;
    pulse_cnt_d  = pulse_cnt_q;
    timer_d      = timer_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          remaining_d  = req_amount_i;
          coin_count_d = '0;
          fault_d      = 1'b0;
          state_d      = ST_SELECT;
        end
      end

      ST_SELECT: begin
        pulse_cnt_d = '0;
        if (remaining_q == '0) begin
          state_d = ST_FINISH;
        end else if (can5_c) begin
          sel_d   = 3'b100;
          state_d = ST_FIRE;
        end else if (can2_c) begin
          sel_d   = 3'b010;
          state_d = ST_FIRE;
        end else if (can1_c) begin
          sel_d   = 3'b001;
          state_d = ST_FIRE;
        end else begin
          fault_d = 1'b1;
          state_d = ST_FINISH;
        end
      end

      ST_FIRE: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          timer_d = '0;
          state_d = ST_WAIT_ACK;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PCNT_W'(1);
        end
      end

      ST_WAIT_ACK: begin
        // A confirmation on the final timer cycle still counts as a paid coin
        if (sense_hit_c) begin
          remaining_d = remaining_q - sel_val_c;
          if (coin_count_q != '1) begin
            coin_count_d = coin_count_q + AMT_W'(1);
          end
          state_d = ST_SELECT;
        end else if (timer_q == TMO_LAST) begin
          fault_d = 1'b1;
          state_d = ST_FINISH;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake and hopper drive decoded from registered state only
  assign req_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_FINISH);
  assign coin_fire_o  = (state_q == ST_FIRE) ? sel_q : 3'b000;
  assign fault_o      = fault_q;
  assign remaining_o  = remaining_q;
  assign coin_count_o = coin_count_q;

endmodule

// File: tb/tb_change_dispense_sequencer.sv
// Testbench for change_dispense_sequencer: a transaction-level model builds the
// expected per-cycle outputs and the sense replies for each request; one
// compare process checks the DUT against it every cycle, plus literal checks.
module tb_change_dispense_sequencer;

  localparam int unsigned AMT_W = 8;
  localparam int unsigned P     = 3;
  localparam int unsigned A     = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_ready;
  logic [2:0]       hopper_empty = 3'b000;
  logic [2:0]       coin_sense = 3'b000;
  logic [2:0]       coin_fire;
  logic             busy;
  logic             done;
  logic             fault;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] coin_count;

  change_dispense_sequencer #(
    .AMT_W(AMT_W), .PULSE_CYCLES(P), .ACK_TIMEOUT(A)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_amount_i(req_amount), .req_ready_o(req_ready),
    .hopper_empty_i(hopper_empty), .coin_sense_i(coin_sense),
    .coin_fire_o(coin_fire), .busy_o(busy), .done_o(done), .fault_o(fault),
    .remaining_o(remaining), .coin_count_o(coin_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] fire;
    bit         busy;
    bit         ready;
    bit         done;
    bit         chk;
    int         rem;
    int         cnt;
    bit         flt;
  } exp_t;

  exp_t       exp_q[int];
  logic [2:0] sense_q[int];

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         fire_log = 0;
  int         fire_cycles = 0;
  int         last_done_cyc = -1;
  logic [2:0] prev_fire = 3'b000;
  exp_t       ce;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Single compare process against the model's per-cycle expectations
  always @(negedge clk) begin
    if (rst_n && exp_q.exists(cyc)) begin
      ce = exp_q[cyc];
      check("coin_fire", int'(coin_fire), int'(ce.fire));
      check("busy", int'(busy), int'(ce.busy));
      check("req_ready", int'(req_ready), int'(ce.ready));
      check("done", int'(done), int'(ce.done));
      if (ce.chk) begin
        check("remaining", int'(remaining), ce.rem);
        check("coin_count", int'(coin_count), ce.cnt);
        check("fault", int'(fault), int'(ce.flt));
      end
    end
    if (coin_fire != 3'b000) begin
      fire_cycles++;
      if (prev_fire == 3'b000) fire_log = (fire_log << 3) | int'(coin_fire);
    end
    if (done) last_done_cyc = cyc;
    prev_fire = coin_fire;
  end

  function automatic int pick(input int rem, input logic [2:0] empty);
    if (rem >= 5 && !empty[2]) return 5;
    if (rem >= 2 && !empty[1]) return 2;
    if (rem >= 1 && !empty[0]) return 1;
    return 0;
  endfunction

  function automatic void put(input int c, input logic [2:0] f, input bit b, input bit r,
                              input bit d, input bit k, input int rem, input int cnt,
                              input bit flt);
    exp_t e;
    e.fire = f; e.busy = b; e.ready = r; e.done = d; e.chk = k;
    e.rem = rem; e.cnt = cnt; e.flt = flt;
    exp_q[c] = e;
  endfunction

  // Transaction model: greedy payout timeline for a request accepted in cycle T.
  // k = cycles into the ack wait before the bench returns sense (<0: never).
  task automatic build(input int t0, input int amt, input logic [2:0] empty, input int k,
                       input bit stray, output int done_c);
    int rem, cnt, t, v, w;
    bit flt, fin;
    logic [2:0] oh;
    rem = amt; cnt = 0; flt = 0; fin = 0;
    put(t0, 3'b000, 0, 1, 0, 0, 0, 0, 0);
    t = t0 + 1;
    while (!fin) begin
      put(t, 3'b000, 1, 0, 0, 1, rem, cnt, 0);
      v = pick(rem, empty);
      if (rem == 0) begin
        fin = 1; t = t + 1;
      end else if (v == 0) begin
        flt = 1; fin = 1; t = t + 1;
      end else begin
        oh = (v == 5) ? 3'b100 : ((v == 2) ? 3'b010 : 3'b001);
        for (int i = 1; i <= int'(P); i++) put(t + i, oh, 1, 0, 0, 1, rem, cnt, 0);
        if (stray && oh != 3'b001) sense_q[t + 2] = 3'b001;
        w = t + int'(P) + 1;
        if (k < 0 || k >= int'(A)) begin
          for (int i = 0; i < int'(A); i++) put(w + i, 3'b000, 1, 0, 0, 1, rem, cnt, 0);
          flt = 1; fin = 1; t = w + int'(A);
        end else begin
          for (int i = 0; i <= k; i++) put(w + i, 3'b000, 1, 0, 0, 1, rem, cnt, 0);
          if (stray && k >= 1 && oh != 3'b001) sense_q[w] = 3'b001;
          sense_q[w + k] = oh;
          rem = rem - v;
          cnt = (cnt < 255) ? cnt + 1 : cnt;
          t = w + k + 1;
        end
      end
    end
    put(t, 3'b000, 1, 0, 1, 1, rem, cnt, flt);
    put(t + 1, 3'b000, 0, 1, 0, 1, rem, cnt, flt);
    done_c = t;
  endtask

  // Drive one request; entered and left at 1 time unit after a rising edge
  task automatic run_txn(input int amt, input logic [2:0] empty, input int k, input bit stray,
                         input bit busy_req, input bit do_reset, output int t0, output int done_c);
    bit hit;
    t0 = cyc;
    build(t0, amt, empty, k, stray, done_c);
    fire_log = 0; fire_cycles = 0;
    req_valid = 1'b1; req_amount = AMT_W'(amt); hopper_empty = empty; coin_sense = 3'b000;
    for (int c = t0 + 1; c <= done_c + 1; c++) begin
      @(posedge clk); #1;
      req_valid  = busy_req && (c == t0 + 1);
      req_amount = busy_req ? AMT_W'(7) : AMT_W'(amt);
      coin_sense = sense_q.exists(c) ? sense_q[c] : 3'b000;
      hit = 0;
      if (do_reset && exp_q.exists(c) && exp_q.exists(c - 1)) begin
        if (exp_q[c].fire == 3'b010 && exp_q[c - 1].fire == 3'b010) hit = 1;
      end
      if (hit) begin
        for (int x = c; x <= done_c + 1; x++) begin
          exp_q.delete(x);
          sense_q.delete(x);
        end
        coin_sense = 3'b000;
        check("rst_pre_fire", int'(coin_fire), 2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_fire", int'(coin_fire), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_count", int'(coin_count), 0);
        check("rst_ready", int'(req_ready), 1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", int'(req_ready), 1);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_fire", int'(coin_fire), 0);
        break;
      end
    end
    req_valid = 1'b0; coin_sense = 3'b000;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, dc;
    #1 rst_n = 1'b0;
    #2;
    check("reset_fire", int'(coin_fire), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_fault", int'(fault), 0);
    check("reset_remaining", int'(remaining), 0);
    check("reset_count", int'(coin_count), 0);
    check("reset_ready", int'(req_ready), 1);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 8 = 5+2+1, all hoppers stocked
    run_txn(8, 3'b000, 2, 0, 0, 0, t0, dc);
    check("t1_order", fire_log, 9'b100_010_001);
    check("t1_remaining", int'(remaining), 0);
    check("t1_count", int'(coin_count), 3);
    check("t1_fault", int'(fault), 0);

    // 8 with 1-unit hopper empty: 5+2 then fault, residue 1
    run_txn(8, 3'b001, 2, 0, 0, 0, t0, dc);
    check("t2_order", fire_log, 6'b100_010);
    check("t2_remaining", int'(remaining), 1);
    check("t2_count", int'(coin_count), 2);
    check("t2_fault", int'(fault), 1);

    // 6 with no sense: single 5 pulse then timeout
    run_txn(6, 3'b000, -1, 0, 0, 0, t0, dc);
    check("t3_order", fire_log, 3'b100);
    check("t3_pulse_len", fire_cycles, int'(P));
    check("t3_done_lat", last_done_cyc - t0, 2 + int'(P) + int'(A));
    check("t3_remaining", int'(remaining), 6);
    check("t3_count", int'(coin_count), 0);
    check("t3_fault", int'(fault), 1);

    // Zero amount, plus a request offered while busy
    run_txn(0, 3'b000, 0, 0, 1, 0, t0, dc);
    check("t4_no_fire", fire_cycles, 0);
    check("t4_done_lat", last_done_cyc - t0, 2);
    check("t4_remaining", int'(remaining), 0);
    check("t4_fault", int'(fault), 0);
    check("t4_idle", int'(busy), 0);

    // 9 with reset during the second coin's fire pulse
    run_txn(9, 3'b000, 1, 0, 0, 1, t0, dc);
    check("t5_remaining", int'(remaining), 0);
    check("t5_count", int'(coin_count), 0);

    // 5 with stray 1-unit sense pulses before the real confirmation
    run_txn(5, 3'b000, 3, 1, 0, 0, t0, dc);
    check("t6_order", fire_log, 3'b100);
    check("t6_remaining", int'(remaining), 0);
    check("t6_count", int'(coin_count), 1);
    check("t6_fault", int'(fault), 0);

    // 4 with 2-unit hopper empty: 1+1+1+1 with immediate sense
    run_txn(4, 3'b010, 0, 0, 0, 0, t0, dc);
    check("t7_order", fire_log, 12'b001_001_001_001);
    check("t7_count", int'(coin_count), 4);
    check("t7_remaining", int'(remaining), 0);
    check("t7_fault", int'(fault), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
